// File: rtl/taxi_axi_crossbar_thread_ctrl.sv
// taxi_axi_crossbar_thread_ctrl: per-ID thread and per-master issue admission for one crossbar address path.
// Optional stall statistics counter enabled by defining TAXI_AXI_XBAR_THREAD_STATS_EN.
module taxi_axi_crossbar_thread_ctrl #(
    parameter int M_COUNT = 4,
    parameter int ID_W = 8,
    parameter int S_THREADS = 2,
    parameter int S_ACCEPT = 16,
    parameter logic [M_COUNT*32-1:0] M_ISSUE = {M_COUNT{32'd4}},
    parameter int SEL_W = $clog2(M_COUNT+1),
    parameter int CNT_W = $clog2(S_ACCEPT+1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ID_W-1:0]    req_id,
    input  logic [SEL_W-1:0]   req_sel,
    input  logic               cpl_valid,
    input  logic [ID_W-1:0]    cpl_id,
    output logic               cpl_err,
    output logic [M_COUNT-1:0] m_busy,
    output logic [CNT_W-1:0]   outstanding,
    output logic [15:0]        stall_cnt
);
    localparam int IDX_W = S_THREADS > 1 ? $clog2(S_THREADS) : 1;

    logic [ID_W-1:0]     r_id [S_THREADS];
    logic [SEL_W-1:0]    r_sel [S_THREADS];
    logic [CNT_W-1:0]    r_cnt [S_THREADS];
    logic [CNT_W-1:0]    r_issue [M_COUNT];
    logic [CNT_W-1:0]    r_out;
    logic                r_cpl_err;
    logic [2**SEL_W-1:0] w_issue_ok;
    logic                w_req_hit, w_free, w_cpl_hit, w_acc, w_cpl;
    logic [IDX_W-1:0]    w_req_idx, w_free_idx, w_cpl_idx;
    logic [SEL_W-1:0]    w_cpl_sel;

    // A slot is active while its count is nonzero; descending scan leaves the lowest index
    always_comb begin
        w_req_hit = 1'b0;
        w_req_idx = '0;
        w_free = 1'b0;
        w_free_idx = '0;
        w_cpl_hit = 1'b0;
        w_cpl_idx = '0;
        for (int i = S_THREADS-1; i >= 0; i--) begin
            if (r_cnt[i] == '0) begin
                w_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            if (r_cnt[i] != '0 && r_id[i] == req_id) begin
                w_req_hit = 1'b1;
                w_req_idx = IDX_W'(i);
            end
            if (r_cnt[i] != '0 && r_id[i] == cpl_id) begin
                w_cpl_hit = 1'b1;
                w_cpl_idx = IDX_W'(i);
            end
        end
        w_issue_ok = '1;
        for (int m = 0; m < M_COUNT; m++)
            w_issue_ok[m] = 32'(r_issue[m]) < M_ISSUE[m*32 +: 32];
        m_busy = '0;
        for (int m = 0; m < M_COUNT; m++)
            m_busy[m] = r_issue[m] != '0;
    end

    assign req_ready = !rst && r_out < CNT_W'(S_ACCEPT) && w_issue_ok[req_sel] &&
                       (w_req_hit ? r_sel[w_req_idx] == req_sel : w_free);
    assign w_acc = req_valid && req_ready;
    assign w_cpl = cpl_valid && w_cpl_hit;
    assign w_cpl_sel = r_sel[w_cpl_idx];
    assign outstanding = r_out;
    assign cpl_err = r_cpl_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < S_THREADS; i++) begin
                r_cnt[i] <= '0;
                r_id[i] <= '0;
                r_sel[i] <= '0;
            end
            for (int m = 0; m < M_COUNT; m++)
                r_issue[m] <= '0;
            r_out <= '0;
            r_cpl_err <= 1'b0;
        end else begin
            for (int i = 0; i < S_THREADS; i++) begin
                r_cnt[i] <= r_cnt[i]
                    + CNT_W'(w_acc && (w_req_hit ? w_req_idx == IDX_W'(i) : w_free_idx == IDX_W'(i)))
                    - CNT_W'(w_cpl && w_cpl_idx == IDX_W'(i));
                if (w_acc && !w_req_hit && w_free_idx == IDX_W'(i)) begin
                    r_id[i] <= req_id;
                    r_sel[i] <= req_sel;
                end
            end
            // Sink selects never match a master index, so they skip issue counting
            for (int m = 0; m < M_COUNT; m++)
                r_issue[m] <= r_issue[m] + CNT_W'(w_acc && req_sel == SEL_W'(m))
                              - CNT_W'(w_cpl && w_cpl_sel == SEL_W'(m));
            r_out <= r_out + CNT_W'(w_acc) - CNT_W'(w_cpl);
            r_cpl_err <= cpl_valid && !w_cpl_hit;
        end
    end

`ifdef TAXI_AXI_XBAR_THREAD_STATS_EN
    logic [15:0] r_stall;
    always_ff @(posedge clk) begin
        if (rst)
            r_stall <= '0;
        else if (req_valid && !req_ready && r_stall != 16'hFFFF)
            r_stall <= r_stall + 16'd1;
    end
    assign stall_cnt = r_stall;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_taxi_axi_crossbar_thread_ctrl.sv
// tb_taxi_axi_crossbar_thread_ctrl: directed scoreboard bench for the crossbar thread controller.
// Expected stall_cnt follows TAXI_AXI_XBAR_THREAD_STATS_EN.
module tb_taxi_axi_crossbar_thread_ctrl;
`ifdef TAXI_AXI_XBAR_THREAD_STATS_EN
    localparam int EXP_STALL = 10;
`else
    localparam int EXP_STALL = 0;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_id = '0;
    logic [2:0] req_sel = '0;
    logic       cpl_valid = 1'b0;
    logic [7:0] cpl_id = '0;
    logic       cpl_err;
    logic [3:0] m_busy;
    logic [4:0] outstanding;
    logic [15:0] stall_cnt;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int q_grant[$];
    int q_err[$];

    taxi_axi_crossbar_thread_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_id(req_id), .req_sel(req_sel), .cpl_valid(cpl_valid), .cpl_id(cpl_id),
        .cpl_err(cpl_err), .m_busy(m_busy), .outstanding(outstanding), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every handshake and every cpl_err pulse must match a queued expectation
    always @(negedge clk) begin
        if (req_valid && req_ready) begin
            if (q_grant.size() == 0) chk("unexpected_grant", cyc, -1);
            else chk("grant_cycle", cyc, q_grant.pop_front());
        end
        if (cpl_err) begin
            if (q_err.size() == 0) chk("unexpected_cpl_err", cyc, -1);
            else chk("cpl_err_cycle", cyc, q_err.pop_front());
        end
    end

    task automatic drive(input logic v, input int id, input int sel, input logic g,
                         input logic cv, input int cid, input logic e);
        @(posedge clk);
        #1;
        req_valid = v;
        req_id = 8'(id);
        req_sel = 3'(sel);
        cpl_valid = cv;
        cpl_id = 8'(cid);
        if (g) q_grant.push_back(cyc);
        if (e) q_err.push_back(cyc + 1);
    endtask

    task automatic req(input int id, input int sel, input logic g);
        drive(1'b1, id, sel, g, 1'b0, 0, 1'b0);
    endtask

    task automatic cpl(input int cid, input logic e);
        drive(1'b0, 0, 0, 1'b0, 1'b1, cid, e);
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic st(input int o, input int b);
        @(negedge clk);
        chk("outstanding", outstanding, o);
        chk("m_busy", m_busy, b);
    endtask

    task automatic do_rst(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 1'b1;
        cpl_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin
        do_rst(3);
        st(0, 0);
        chk("stall_after_rst", stall_cnt, 0);
        chk("cpl_err_after_rst", cpl_err, 0);
        // Back-to-back same ID to master 1
        repeat (3) req(5, 1, 1'b1);
        idle(); st(3, 4'b0010);
        repeat (3) cpl(5, 1'b0);
        idle(); st(0, 0);
        // Same ID to a different master waits for drain
        req(5, 1, 1'b1);
        req(5, 2, 1'b0); st(1, 4'b0010);
        req(5, 2, 1'b0);
        req(5, 2, 1'b0);
        drive(1'b1, 5, 2, 1'b0, 1'b1, 5, 1'b0);
        req(5, 2, 1'b1);
        idle(); st(1, 4'b0100);
        cpl(5, 1'b0);
        idle(); st(0, 0);
        // Thread slots exhausted; freed slot usable only the next cycle
        req(1, 3, 1'b1);
        req(2, 3, 1'b1);
        req(3, 3, 1'b0);
        req(3, 3, 1'b0);
        drive(1'b1, 3, 3, 1'b0, 1'b1, 1, 1'b0);
        req(3, 3, 1'b1);
        idle(); st(2, 4'b1000);
        cpl(2, 1'b0);
        cpl(3, 1'b0);
        idle(); st(0, 0);
        // Master 0 issue limit of 4
        req(7, 0, 1'b1);
        req(8, 0, 1'b1);
        req(7, 0, 1'b1);
        req(7, 0, 1'b1);
        req(7, 0, 1'b0); st(4, 4'b0001);
        req(7, 0, 1'b0);
        drive(1'b1, 7, 0, 1'b0, 1'b1, 8, 1'b0);
        req(7, 0, 1'b1);
        idle(); st(4, 4'b0001);
        cpl(7, 1'b0);
        drive(1'b1, 7, 0, 1'b1, 1'b1, 7, 1'b0);
        idle(); st(3, 4'b0001);
        req(7, 0, 1'b1);
        req(7, 0, 1'b0);
        repeat (4) cpl(7, 1'b0);
        idle(); st(0, 0);
        // Reset mid-operation discards tracking
        req(9, 2, 1'b1);
        do_rst(2);
        st(0, 0);
        cpl(9, 1'b1);
        idle(); st(0, 0);
        // Sink fills S_ACCEPT, then a 10-cycle stall
        repeat (16) req(32, 4, 1'b1);
        repeat (10) req(32, 4, 1'b0);
        idle(); st(16, 0);
        chk("stall_cnt", stall_cnt, EXP_STALL);
        cpl(9, 1'b1);
        idle(); st(16, 0);
        repeat (16) cpl(32, 1'b0);
        idle(); st(0, 0);
        idle();
        idle();
        @(negedge clk);
        chk("grant_pending", q_grant.size(), 0);
        chk("cpl_err_pending", q_err.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
